fp16_accumulator: RTL
=====================

# fp16_accumulator

Sequential dot-product accumulator for the FPU datapath of the sparse matrix multiplier. It consumes a stream of half-precision products (one row's partial products, terminated by `in_last`) and drives the 4-stage half-precision adder directly downstream, one addition at a time, through its `clk_en`/`dataa`/`datab`/`result` ports. When the row ends it presents the final sum, the element count and sticky exception flags on a valid/ready output.

## Interface
- `ADD_LATENCY`, 4: clock edges from the edge that samples `add_en` high to the edge that captures `add_result`; must be ≥ 4.
- `COUNT_W`, 16: width of the element counter.
- `clock`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  product available.
- `in_ready`  out  1  accumulator accepts a product this cycle.
- `in_data`  in  16  IEEE754 binary16 product.
- `in_last`  in  1  marks the final product of the row; qualified by `in_valid`.
- `add_en`  out  1  drives the adder's `clk_en`.
- `add_a`  out  16  drives the adder's `dataa` (running sum).
- `add_b`  out  16  drives the adder's `datab` (held product).
- `add_result`  in  16  the adder's `result`.
- `add_overflow`  in  1  the adder's `overflow`.
- `add_underflow`  in  1  the adder's `underflow`.
- `out_valid`  out  1  row sum available.
- `out_ready`  in  1  consumer accepts the sum.
- `out_data`  out  16  binary16 row sum.
- `out_count`  out  `COUNT_W`  number of products accepted for the row; saturates at all-ones.
- `out_ovf`  out  1  sticky OR of `add_overflow` over the row.
- `out_unf`  out  1  sticky OR of `add_underflow` over the row.

## Operation
- Registers: `acc` (16), `hold` (16), `last_q`, `count`, `ovf`, `unf`, `wait_cnt`, state.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid` with `in_ready` high: `hold` ← `in_data`, `last_q` ← `in_last`, `count` increments (saturating), then go to ISSUE.
- ISSUE (exactly one cycle):
  - `add_en` = 1, `add_a` = `acc`, `add_b` = `hold`; `wait_cnt` ← 1.
  - Go to WAIT.
- WAIT:
  - `add_en` = 0; `add_a` and `add_b` hold their ISSUE values.
  - `wait_cnt` increments each edge.
  - At the edge where `wait_cnt` = `ADD_LATENCY`: `acc` ← `add_result`, `ovf` |= `add_overflow`, `unf` |= `add_underflow`.
  - Then go to DONE if `last_q`, else to IDLE.
- DONE:
  - `out_valid` = 1; `out_data` = `acc`, `out_count` = `count`, `out_ovf` = `ovf`, `out_unf` = `unf`.
  - All output fields stay stable while `out_ready` is low.
  - On `out_ready`: `acc`, `count`, `ovf` and `unf` clear to 0, then go to IDLE.
- First product of a row is added to `acc` = 0x0000, so a one-element row returns the adder's result for 0 + x.
- `in_ready` is low in ISSUE, WAIT and DONE; `out_valid` is low outside DONE.
- Reset (at any time, including mid-WAIT): state → IDLE; all registers and outputs are 0 (`in_ready` = 1 in IDLE); `add_en` deasserts immediately.

## Timing
- Accept at edge E0 → `add_en` high during the cycle after E0 → adder samples it at E1 → capture at E1+`ADD_LATENCY` (E5 by default).
- Last product: `out_valid` rises after E5, 5 cycles after acceptance.
- Non-last product: `in_ready` rises after E5; the next accept is at E6 at the earliest, so throughput is one product per `ADD_LATENCY`+2 cycles.
- `out_valid` to the next `in_ready`: one edge after the `out_ready` handshake.

## Configuration
- `ACC_SKIP_ZERO_EN` defined: an accepted product with bits [14:0] = 0 (+0 or −0) skips ISSUE/WAIT.
  - `count` still increments.
  - State goes to DONE if `in_last`, else stays in IDLE; `in_ready` remains high the next cycle.
- `ACC_SKIP_ZERO_EN` not defined: every product goes through ISSUE/WAIT, with identical latency for zeros.

## Test plan
- Products 0x3C00, 0x4000 (last) with `out_ready` = 1 → `out_data` = 0x4200, `out_count` = 2, `out_ovf`/`out_unf` reflect the adder's flags; `add_en` pulses exactly twice, each for one cycle.
- Single product 0x3800 (last) accepted at E0 → `add_en` high only in cycle E0+1; `out_valid` high 5 cycles after E0, `out_data` = 0x3800.
- Products 0x3E00, 0x3E00 (last) with `out_ready` held low 10 cycles → `out_valid`, `out_data` = 0x4200 and `out_count` = 2 stay stable; `in_ready` stays low until one edge after the `out_ready` handshake.
- `in_valid` held high continuously over 3 products → accepts spaced exactly 6 cycles apart; `in_ready` is never high in ISSUE or WAIT.
- Reset asserted mid-WAIT of the second product → `add_en` = 0, `out_valid` = 0, `in_ready` = 1; the next row 0x3C00 (last) yields 0x3C00 with `out_count` = 1.
- With `ACC_SKIP_ZERO_EN` defined: 0x0000, 0x8000, 0x4000 (last) → one `add_en` pulse, `out_data` = 0x4000, `out_count` = 3.

Source files
------------

// File: rtl/fp16_accumulator.sv
// rtl/fp16_accumulator.sv - sequential binary16 row accumulator driving a pipelined half-precision adder
// Optional feature macro: ACC_SKIP_ZERO_EN lets +0/-0 products bypass the adder round trip.
module fp16_accumulator #(
  parameter int ADD_LATENCY = 4,
  parameter int COUNT_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [15:0]        in_data,
  input  logic               in_last,
  output logic               add_en,
  output logic [15:0]        add_a,
  output logic [15:0]        add_b,
  input  logic [15:0]        add_result,
  input  logic               add_overflow,
  input  logic               add_underflow,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [15:0]        out_data,
  output logic [COUNT_W-1:0] out_count,
  output logic               out_ovf,
  output logic               out_unf
);

  localparam int WC_W = $clog2(ADD_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t             state;
  logic [15:0]        acc;
  logic [15:0]        hold;
  logic               last_q;
  logic [COUNT_W-1:0] count;
  logic               ovf;
  logic               unf;
  logic [WC_W-1:0]    wait_cnt;
  logic [COUNT_W-1:0] count_inc;

  assign count_inc = (&count) ? count : count + 1'b1;

  // acc and hold only change outside ISSUE/WAIT, so the adder operands stay put for the whole add
  assign add_a     = acc;
  assign add_b     = hold;
  assign out_data  = acc;
  assign out_count = count;
  assign out_ovf   = ovf;
  assign out_unf   = unf;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      acc       <= 16'h0000;
      hold      <= 16'h0000;
      last_q    <= 1'b0;
      count     <= '0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
      wait_cnt  <= '0;
      in_ready  <= 1'b1;
      add_en    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            hold   <= in_data;
            last_q <= in_last;
            count  <= count_inc;
`ifdef ACC_SKIP_ZERO_EN
            if (in_data[14:0] == 15'd0) begin
              if (in_last) begin
                state     <= DONE;
                in_ready  <= 1'b0;
                out_valid <= 1'b1;
              end
            end else begin
              state    <= ISSUE;
              in_ready <= 1'b0;
              add_en   <= 1'b1;
            end
`else
            state    <= ISSUE;
            in_ready <= 1'b0;
            add_en   <= 1'b1;
`endif
          end
        end
        ISSUE: begin
          add_en   <= 1'b0;
          wait_cnt <= WC_W'(1);
          state    <= WAIT;
        end
        WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (wait_cnt == WC_W'(ADD_LATENCY)) begin
            acc <= add_result;
            ovf <= ovf | add_overflow;
            unf <= unf | add_underflow;
            if (last_q) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end else begin
              state    <= IDLE;
              in_ready <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            acc       <= 16'h0000;
            count     <= '0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          add_en    <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
